// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Sequential front end for the 32-bit combinational ALU. Requests arrive over a
// valid/ready handshake, are decoded into ALU control/bonus codes and issued to
// the ALU. The ALU outputs are captured one cycle later into an in-order
// response FIFO that the consumer drains with its own valid/ready handshake.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_op/req_a/req_b/req_tag  opcode, operands, tag echoed in the response
//   rsp_valid/rsp_ready       response handshake (FIFO head)
//   rsp_result/zero/cout/overflow/err/tag  response payload
//   alu_rst_n, alu_src1/src2, alu_control, alu_bonus   drive to the ALU
//   alu_result, alu_zero/cout/overflow                 results from the ALU
//   req_cnt                   accepted requests, wraps
//   ovf_cnt                   responses with overflow set, saturates
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic             rsp_cout,
   output logic             rsp_overflow,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             alu_rst_n,
   output logic [31:0]      alu_src1,
   output logic [31:0]      alu_src2,
   output logic [3:0]       alu_control,
   output logic [2:0]       alu_bonus,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   input  logic             alu_cout,
   input  logic             alu_overflow,
   output logic [15:0]      req_cnt,
   output logic [15:0]      ovf_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0]      result;
      logic             zero;
      logic             cout;
      logic             overflow;
      logic             err;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic             accept;
   logic             push;
   logic             pop;
   logic [3:0]       decCtrl;
   logic [2:0]       decBonus;
   logic             decErr;
   entry_t           pushEntry;

   logic [31:0]      src1_q, src2_q;
   logic [3:0]       ctrl_q;
   logic [2:0]       bonus_q;
   logic [TAG_W-1:0] tag_q;
   logic             err_q;
   logic             inFlight_q;
   logic             aluRstN_q;

   entry_t           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] occupancy;
   logic [15:0]      reqCnt_q, reqCnt_d;
   logic [15:0]      ovfCnt_q, ovfCnt_d;

   // Opcode decode. Codes 12..15 are illegal: the ALU sees AND (0000/000)
   // and the captured response is overridden with an error entry.
   always_comb begin
      decCtrl  = 4'b0000;
      decBonus = 3'b000;
      decErr   = 1'b0;
      case (req_op)
         4'd0:    decCtrl = 4'b0000;
         4'd1:    decCtrl = 4'b0001;
         4'd2:    decCtrl = 4'b0010;
         4'd3:    decCtrl = 4'b0110;
         4'd4:    decCtrl = 4'b1100;
         4'd5:    decCtrl = 4'b1101;
         4'd6:    begin decCtrl = 4'b0111; decBonus = 3'b000; end
         4'd7:    begin decCtrl = 4'b0111; decBonus = 3'b001; end
         4'd8:    begin decCtrl = 4'b0111; decBonus = 3'b010; end
         4'd9:    begin decCtrl = 4'b0111; decBonus = 3'b011; end
         4'd10:   begin decCtrl = 4'b0111; decBonus = 3'b110; end
         4'd11:   begin decCtrl = 4'b0111; decBonus = 3'b100; end
         default: decErr = 1'b1;
      endcase
   end

   // Admission counts the in-flight item so it always has a FIFO slot when it
   // lands. Only registers and rst feed req_ready, never rsp_ready.
   always_comb begin
      occupancy = count_q + CNT_W'(inFlight_q);
      req_ready = ~rst & (occupancy < CNT_W'(FIFO_DEPTH));
      accept    = req_valid & req_ready;
      push      = inFlight_q;
      pop       = rsp_ready & (count_q != '0);
   end

   // Issue stage: operands and decoded controls are held in the ALU drive
   // registers until the next accepted request replaces them.
   always_ff @(posedge clk) begin
      if (rst) begin
         src1_q     <= '0;
         src2_q     <= '0;
         ctrl_q     <= '0;
         bonus_q    <= '0;
         tag_q      <= '0;
         err_q      <= 1'b0;
         inFlight_q <= 1'b0;
         aluRstN_q  <= 1'b0;
      end else begin
         inFlight_q <= accept;
         aluRstN_q  <= 1'b1;
         if (accept) begin
            src1_q  <= req_a;
            src2_q  <= req_b;
            ctrl_q  <= decCtrl;
            bonus_q <= decBonus;
            tag_q   <= req_tag;
            err_q   <= decErr;
         end
      end
   end

   // Capture stage payload; an illegal opcode discards whatever the ALU
   // computed and reports a clean error entry instead.
   always_comb begin
      pushEntry.result   = alu_result;
      pushEntry.zero     = alu_zero;
      pushEntry.cout     = alu_cout;
      pushEntry.overflow = alu_overflow;
      pushEntry.err      = 1'b0;
      pushEntry.tag      = tag_q;
      if (err_q) begin
         pushEntry.result   = '0;
         pushEntry.zero     = 1'b0;
         pushEntry.cout     = 1'b0;
         pushEntry.overflow = 1'b0;
         pushEntry.err      = 1'b1;
      end
   end

   // Next-state for FIFO pointers/occupancy and the statistics counters.
   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wrPtr_d  = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d  = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      reqCnt_d = accept ? reqCnt_q + 16'd1 : reqCnt_q;
      ovfCnt_d = ovfCnt_q;
      if (push && pushEntry.overflow && (ovfCnt_q != 16'hFFFF)) begin
         ovfCnt_d = ovfCnt_q + 16'd1;
      end
   end

   // Control state of the FIFO and counters; reset flushes everything at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         reqCnt_q <= '0;
         ovfCnt_q <= '0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         count_q  <= count_d;
         reqCnt_q <= reqCnt_d;
         ovfCnt_q <= ovfCnt_d;
      end
   end

   // Storage needs no reset: entries are only visible while count is nonzero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= pushEntry;
      end
   end

   // Head of the FIFO is presented directly; forced to zero when empty so the
   // response bus is quiet after reset and between bursts.
   always_comb begin
      rsp_valid    = (count_q != '0);
      rsp_result   = '0;
      rsp_zero     = 1'b0;
      rsp_cout     = 1'b0;
      rsp_overflow = 1'b0;
      rsp_err      = 1'b0;
      rsp_tag      = '0;
      if (rsp_valid) begin
         rsp_result   = mem_q[rdPtr_q].result;
         rsp_zero     = mem_q[rdPtr_q].zero;
         rsp_cout     = mem_q[rdPtr_q].cout;
         rsp_overflow = mem_q[rdPtr_q].overflow;
         rsp_err      = mem_q[rdPtr_q].err;
         rsp_tag      = mem_q[rdPtr_q].tag;
      end
   end

   assign alu_rst_n   = aluRstN_q;
   assign alu_src1    = src1_q;
   assign alu_src2    = src2_q;
   assign alu_control = ctrl_q;
   assign alu_bonus   = bonus_q;
   assign req_cnt     = reqCnt_q;
   assign ovf_cnt     = ovfCnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl. A behavioural ALU responds to the DUT's ALU drive
// pins; a reference model computes each response straight from the opcode and
// operands. Expected responses are queued at accept time and a monitor pops
// and compares them whenever the DUT hands out a response.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 4;

   typedef struct packed {
      logic [31:0]      result;
      logic             zero;
      logic             cout;
      logic             ovf;
      logic             err;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [31:0]      req_a, req_b;
   logic [TAG_W-1:0] req_tag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_result;
   logic             rsp_zero, rsp_cout, rsp_overflow, rsp_err;
   logic [TAG_W-1:0] rsp_tag;
   logic             alu_rst_n;
   logic [31:0]      alu_src1, alu_src2;
   logic [3:0]       alu_control;
   logic [2:0]       alu_bonus;
   logic [31:0]      alu_result;
   logic             alu_zero, alu_cout, alu_overflow;
   logic [15:0]      req_cnt, ovf_cnt;

   exp_t sb[$];
   int   vectorsApplied = 0;
   int   miscompares    = 0;
   int   expReqCnt      = 0;
   int   expOvfCnt      = 0;
   int   rspMode        = 0;

   alu_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
      .rsp_err(rsp_err), .rsp_tag(rsp_tag),
      .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .alu_control(alu_control), .alu_bonus(alu_bonus),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
      .alu_overflow(alu_overflow),
      .req_cnt(req_cnt), .ovf_cnt(ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU keyed on control/bonus codes.
   logic [32:0] aluWide;
   always_comb begin
      aluWide      = '0;
      alu_result   = '0;
      alu_cout     = 1'b0;
      alu_overflow = 1'b0;
      if (alu_rst_n) begin
         case (alu_control)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: begin
               aluWide      = {1'b0, alu_src1} + {1'b0, alu_src2};
               alu_result   = aluWide[31:0];
               alu_cout     = aluWide[32];
               alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_result[31] != alu_src1[31]);
            end
            4'b0110: begin
               aluWide      = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
               alu_result   = aluWide[31:0];
               alu_cout     = aluWide[32];
               alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_result[31] != alu_src1[31]);
            end
            4'b1100: alu_result = ~(alu_src1 | alu_src2);
            4'b1101: alu_result = ~(alu_src1 & alu_src2);
            4'b0111: begin
               case (alu_bonus)
                  3'b000:  alu_result = {31'b0, $signed(alu_src1) <  $signed(alu_src2)};
                  3'b001:  alu_result = {31'b0, $signed(alu_src1) >  $signed(alu_src2)};
                  3'b010:  alu_result = {31'b0, $signed(alu_src1) <= $signed(alu_src2)};
                  3'b011:  alu_result = {31'b0, $signed(alu_src1) >= $signed(alu_src2)};
                  3'b110:  alu_result = {31'b0, alu_src1 == alu_src2};
                  3'b100:  alu_result = {31'b0, alu_src1 != alu_src2};
                  default: alu_result = '0;
               endcase
            end
            default: alu_result = '0;
         endcase
      end
      alu_zero = alu_rst_n & (alu_result == 32'd0);
   end

   // Reference model: what a response must contain, from the opcode meaning.
   function automatic exp_t refModel(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [TAG_W-1:0] tag);
      exp_t   e;
      int     sa, sb2;
      longint wideSum;
      logic [63:0] usum;
      e = '0;
      e.tag = tag;
      sa = a;
      sb2 = b;
      case (op)
         4'd0: e.result = a & b;
         4'd1: e.result = a | b;
         4'd2: begin
            usum     = 64'(a) + 64'(b);
            e.result = usum[31:0];
            e.cout   = usum[32];
            wideSum  = longint'(sa) + longint'(sb2);
            e.ovf    = (wideSum != longint'(int'(wideSum)));
         end
         4'd3: begin
            e.result = a - b;
            e.cout   = (a >= b);
            wideSum  = longint'(sa) - longint'(sb2);
            e.ovf    = (wideSum != longint'(int'(wideSum)));
         end
         4'd4:  e.result = ~(a | b);
         4'd5:  e.result = ~(a & b);
         4'd6:  e.result = 32'(sa <  sb2);
         4'd7:  e.result = 32'(sa >  sb2);
         4'd8:  e.result = 32'(sa <= sb2);
         4'd9:  e.result = 32'(sa >= sb2);
         4'd10: e.result = 32'(a == b);
         4'd11: e.result = 32'(a != b);
         default: e.err = 1'b1;
      endcase
      if (!e.err) e.zero = (e.result == 32'd0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Offer one request for exactly one cycle; called at a falling edge.
   task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, output bit accepted);
      exp_t e;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      #1;
      accepted = req_ready;
      if (accepted) begin
         e = refModel(op, a, b, tag);
         sb.push_back(e);
         expReqCnt++;
         if (e.ovf) expOvfCnt++;
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Hold a request until accepted, bounded.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tag);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 64 && !acc; i++) offer(op, a, b, tag, acc);
      if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 300 && (sb.size() != 0 || rsp_valid); i++) @(negedge clk);
      #1;
      checkOutput("drain", 64'(sb.size()), 64'd0);
      checkOutput("req_cnt", 64'(req_cnt), 64'(expReqCnt % 65536));
      checkOutput("ovf_cnt", 64'(ovf_cnt), 64'((expOvfCnt > 65535) ? 65535 : expOvfCnt));
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Consumer-side ready: 0 = stall, 1 = always ready, else random.
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rspMode == 0)      rsp_ready = 1'b0;
         else if (rspMode == 1) rsp_ready = 1'b1;
         else                   rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks that a stalled
   // head stays put.
   initial begin : monitor
      exp_t got, prevRsp, expEntry;
      bit   prevStall;
      prevStall = 1'b0;
      prevRsp   = '0;
      forever begin
         @(negedge clk);
         #2;
         got = {rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err, rsp_tag};
         if (rst) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) checkOutput("rsp_hold", 64'({rsp_valid, got}), 64'({1'b1, prevRsp}));
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  vectorsApplied++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_rsp: got %h, expected no response (t=%0t)", got, $time);
               end else begin
                  expEntry = sb.pop_front();
                  checkOutput("response", 64'(got), 64'(expEntry));
               end
            end
            prevStall = rsp_valid && !rsp_ready;
            prevRsp   = got;
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      miscompares++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

   initial begin : main
      logic [3:0]  dOp [13];
      logic [31:0] dA  [13];
      logic [31:0] dB  [13];
      int          nAcc;
      bit          acc;

      dOp = '{4'd3, 4'd6, 4'd9, 4'd7, 4'd8, 4'd10, 4'd11, 4'd0, 4'd1, 4'd4, 4'd5, 4'd2, 4'd3};
      dA  = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'h1234, 32'h1234,
              32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0000FFFF, 32'hFFFFFFFF, 32'h80000000};
      dB  = '{32'd5, 32'd1, 32'd1, 32'h7FFFFFFF, 32'd7, 32'h1234, 32'h1235,
              32'h0FF00FF0, 32'h0FF00FF0, 32'h0000F0F0, 32'h0000FFFF, 32'd1, 32'd1};

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
      rspMode = 0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_rsp_data", 64'({rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err, rsp_tag}), 64'd0);
      checkOutput("rst_alu_drive", 64'({alu_src1, alu_control, alu_bonus}), 64'd0);
      checkOutput("rst_alu_src2", 64'(alu_src2), 64'd0);
      checkOutput("rst_alu_rst_n", 64'(alu_rst_n), 64'd0);
      checkOutput("rst_counters", 64'({req_cnt, ovf_cnt}), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      #1;
      checkOutput("post_rst_alu_rst_n", 64'(alu_rst_n), 64'd1);
      @(negedge clk);

      // Signed-overflow ADD with latency check
      rspMode = 1;
      @(negedge clk);
      applyStimulus(4'd2, 32'h7FFFFFFF, 32'h00000001, 4'd3);
      #1;
      checkOutput("issue_alu_control", 64'({alu_control, alu_bonus}), 64'({4'b0010, 3'b000}));
      checkOutput("latency_not_early", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      #1;
      checkOutput("latency_valid", 64'(rsp_valid), 64'd1);
      checkOutput("ovf_cnt_first", 64'(ovf_cnt), 64'd1);
      @(negedge clk);

      // Directed operations, issued back to back
      for (int i = 0; i < 13; i++) applyStimulus(dOp[i], dA[i], dB[i], TAG_W'(i));

      // Illegal opcode
      applyStimulus(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9);
      #1;
      checkOutput("illegal_alu_drive", 64'({alu_control, alu_bonus}), 64'd0);
      @(negedge clk);
      waitDrain();
      @(negedge clk);

      // Backpressure: consumer stalled, six offers, four slots
      rspMode = 0;
      repeat (2) @(negedge clk);
      nAcc = 0;
      for (int t = 0; t < 6; t++) begin
         offer(4'd2, 32'(t), 32'(t), TAG_W'(t), acc);
         if (acc) nAcc++;
      end
      checkOutput("bp_accepted", 64'(nAcc), 64'd4);
      #1;
      checkOutput("bp_full_ready", 64'(req_ready), 64'd0);
      repeat (3) @(negedge clk);
      rspMode = 1;
      waitDrain();
      checkOutput("bp_ready_again", 64'(req_ready), 64'd1);
      @(negedge clk);

      // Reset in the middle of a stream
      rspMode = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) applyStimulus(4'd2, 32'h7FFFFFFF, 32'h1, TAG_W'(i + 5));
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("midrst_counters", 64'({req_cnt, ovf_cnt}), 64'd0);
      checkOutput("midrst_alu_rst_n", 64'(alu_rst_n), 64'd0);
      checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
      sb.delete();
      expReqCnt = 0;
      expOvfCnt = 0;
      rst = 1'b0;
      rspMode = 1;
      repeat (10) @(negedge clk);
      #1;
      checkOutput("midrst_no_stale", 64'(rsp_valid), 64'd0);
      checkOutput("midrst_alu_rst_n_back", 64'(alu_rst_n), 64'd1);
      @(negedge clk);

      // Randomized traffic with random consumer backpressure
      rspMode = 2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(), TAG_W'($urandom));
      end
      rspMode = 1;
      waitDrain();
      @(negedge clk);

      // Counter wrap and saturation after a clean reset
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      expReqCnt = 0;
      expOvfCnt = 0;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 65537; i++) applyStimulus(4'd2, 32'h7FFFFFFF, 32'h1, TAG_W'(i));
      waitDrain();
      checkOutput("req_cnt_wrap", 64'(req_cnt), 64'd1);
      checkOutput("ovf_cnt_saturate", 64'(ovf_cnt), 64'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
